// File: rtl/timer_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam bcd_t BCD_MAX  = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

  function automatic logic isBcd(input bcd_t d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of a ripple down-counter: decrements on borrow, wrapping 0 to a per-digit value.
module bcd_down_digit
  import timer_pkg::*;
(
  input  bcd_t digit_i,
  input  logic borrow_i,
  input  bcd_t wrap_i,
  output bcd_t digit_o,
  output logic borrow_o
);

  always_comb begin
    borrow_o = borrow_i && (digit_i == BCD_ZERO);
    if (!borrow_i) begin
      digit_o = digit_i;
    end else if (digit_i == BCD_ZERO) begin
      digit_o = wrap_i;
    end else begin
      digit_o = digit_i - 4'd1;
    end
  end

endmodule

// File: rtl/timer_countdown.sv
// Keypad-loaded MM:SS countdown timer with done hold-off.
// Optional `define TIMER_PAUSE_EN adds a 'pause' input that freezes counting in COUNT.
module timer_countdown
  import timer_pkg::*;
#(
  parameter int SEC_WRAP_TENS = 5,
  parameter int DONE_TICKS    = 3
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [3:0] D,
  input  logic       loadn,
  input  logic       pgt_1hz,
  input  logic       enablen,
`ifdef TIMER_PAUSE_EN
  input  logic       pause,
`endif
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       zero,
  output logic       counting,
  output logic       done
);

  localparam bcd_t       SecWrap   = bcd_t'(SEC_WRAP_TENS);
  localparam logic [3:0] DoneTicks = 4'(DONE_TICKS);

  state_t     state_q, state_d;
  bcd_t       minTens_q, minTens_d;
  bcd_t       minOnes_q, minOnes_d;
  bcd_t       secTens_q, secTens_d;
  bcd_t       secOnes_q, secOnes_d;
  logic [3:0] doneCnt_q, doneCnt_d;
  logic       pgt_q;

  logic       tick;
  logic       holdTick;
  logic       keyValid;
  bcd_t       decMinTens, decMinOnes, decSecTens, decSecOnes;
  logic       borrowSecTens, borrowMinOnes, borrowMinTens, underflow;
  logic       decZero;

  assign tick     = pgt_1hz & ~pgt_q;
  assign keyValid = tick && !loadn && isBcd(D);

`ifdef TIMER_PAUSE_EN
  assign holdTick = pause;
`else
  assign holdTick = 1'b0;
`endif

  // Ripple borrow chain: seconds-ones always borrows, carry-out means we were at 00:00.
  bcd_down_digit uSecOnes (
    .digit_i (secOnes_q),
    .borrow_i(1'b1),
    .wrap_i  (BCD_MAX),
    .digit_o (decSecOnes),
    .borrow_o(borrowSecTens)
  );

  bcd_down_digit uSecTens (
    .digit_i (secTens_q),
    .borrow_i(borrowSecTens),
    .wrap_i  (SecWrap),
    .digit_o (decSecTens),
    .borrow_o(borrowMinOnes)
  );

  bcd_down_digit uMinOnes (
    .digit_i (minOnes_q),
    .borrow_i(borrowMinOnes),
    .wrap_i  (BCD_MAX),
    .digit_o (decMinOnes),
    .borrow_o(borrowMinTens)
  );

  bcd_down_digit uMinTens (
    .digit_i (minTens_q),
    .borrow_i(borrowMinTens),
    .wrap_i  (BCD_MAX),
    .digit_o (decMinTens),
    .borrow_o(underflow)
  );

  assign decZero = (decMinTens == BCD_ZERO) && (decMinOnes == BCD_ZERO) &&
                   (decSecTens == BCD_ZERO) && (decSecOnes == BCD_ZERO);

  always_comb begin
    state_d   = state_q;
    minTens_d = minTens_q;
    minOnes_d = minOnes_q;
    secTens_d = secTens_q;
    secOnes_d = secOnes_q;
    doneCnt_d = doneCnt_q;

    case (state_q)
      IDLE, ENTRY: begin
        // Switching to count mode wins over a simultaneous key strobe.
        if (enablen) begin
          state_d = zero ? IDLE : COUNT;
        end else if (keyValid) begin
          minTens_d = minOnes_q;
          minOnes_d = secTens_q;
          secTens_d = secOnes_q;
          secOnes_d = D;
          state_d   = ENTRY;
        end
      end

      COUNT: begin
        if (!enablen) begin
          state_d = ENTRY;
        end else if (tick && !holdTick && !underflow) begin
          minTens_d = decMinTens;
          minOnes_d = decMinOnes;
          secTens_d = decSecTens;
          secOnes_d = decSecOnes;
          if (decZero) begin
            state_d   = DONE;
            doneCnt_d = 4'd0;
          end
        end
      end

      DONE: begin
        if (tick) begin
          if (!enablen && keyValid) begin
            minTens_d = BCD_ZERO;
            minOnes_d = BCD_ZERO;
            secTens_d = BCD_ZERO;
            secOnes_d = D;
            state_d   = ENTRY;
            doneCnt_d = 4'd0;
          end else if (doneCnt_q + 4'd1 >= DoneTicks) begin
            state_d   = IDLE;
            doneCnt_d = 4'd0;
          end else begin
            doneCnt_d = doneCnt_q + 4'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q   <= IDLE;
      minTens_q <= BCD_ZERO;
      minOnes_q <= BCD_ZERO;
      secTens_q <= BCD_ZERO;
      secOnes_q <= BCD_ZERO;
      doneCnt_q <= 4'd0;
      pgt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      minTens_q <= minTens_d;
      minOnes_q <= minOnes_d;
      secTens_q <= secTens_d;
      secOnes_q <= secOnes_d;
      doneCnt_q <= doneCnt_d;
      pgt_q     <= pgt_1hz;
    end
  end

  assign min_tens = minTens_q;
  assign min_ones = minOnes_q;
  assign sec_tens = secTens_q;
  assign sec_ones = secOnes_q;
  assign zero     = (minTens_q == BCD_ZERO) && (minOnes_q == BCD_ZERO) &&
                    (secTens_q == BCD_ZERO) && (secOnes_q == BCD_ZERO);
  assign counting = (state_q == COUNT);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_timer_countdown.sv
// Scoreboard bench for timer_countdown: integer-arithmetic reference model feeds an expectation queue.
module tb_timer_countdown;

  localparam int SEC_WRAP_TENS = 5;
  localparam int DONE_TICKS    = 3;
`ifdef TIMER_PAUSE_EN
  localparam bit HAS_PAUSE = 1'b1;
`else
  localparam bit HAS_PAUSE = 1'b0;
`endif

  localparam int M_IDLE  = 0;
  localparam int M_ENTRY = 1;
  localparam int M_COUNT = 2;
  localparam int M_DONE  = 3;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] D = 4'd0;
  logic       loadn = 1'b1;
  logic       pgt_1hz = 1'b0;
  logic       enablen = 1'b0;
  logic       pauseIn = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       zero, counting, done;

  always #5 clk = ~clk;

  timer_countdown #(
    .SEC_WRAP_TENS(SEC_WRAP_TENS),
    .DONE_TICKS   (DONE_TICKS)
  ) dut (
    .clk     (clk),
    .clear   (clear),
    .D       (D),
    .loadn   (loadn),
    .pgt_1hz (pgt_1hz),
    .enablen (enablen),
`ifdef TIMER_PAUSE_EN
    .pause   (pauseIn),
`endif
    .min_tens(min_tens),
    .min_ones(min_ones),
    .sec_tens(sec_tens),
    .sec_ones(sec_ones),
    .zero    (zero),
    .counting(counting),
    .done    (done)
  );

  typedef struct packed {
    logic [15:0] digits;
    logic        zero;
    logic        counting;
    logic        done;
  } exp_t;

  exp_t expQ[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: the display is just a 4-digit decimal number mValue.
  int   mValue = 0;
  int   mMode  = M_IDLE;
  int   mCnt   = 0;
  bit   mPgt   = 1'b0;

  task automatic modelStep(input bit c, input bit en, input bit ld, input bit p,
                           input int d, input bit ps);
    bit tk;
    bit key;
    int mm;
    int ss;
    if (c) begin
      mValue = 0;
      mMode  = M_IDLE;
      mCnt   = 0;
      mPgt   = 1'b0;
      return;
    end
    tk   = p && !mPgt;
    mPgt = p;
    key  = tk && !ld && (d <= 9);
    case (mMode)
      M_IDLE, M_ENTRY: begin
        if (en) begin
          mMode = (mValue == 0) ? M_IDLE : M_COUNT;
        end else if (key) begin
          mValue = (mValue * 10 + d) % 10000;
          mMode  = M_ENTRY;
        end
      end
      M_COUNT: begin
        if (!en) begin
          mMode = M_ENTRY;
        end else if (tk && !(HAS_PAUSE && ps) && mValue != 0) begin
          mm = mValue / 100;
          ss = mValue % 100;
          if (ss > 0) begin
            ss = ss - 1;
          end else begin
            mm = mm - 1;
            ss = SEC_WRAP_TENS * 10 + 9;
          end
          mValue = mm * 100 + ss;
          if (mValue == 0) begin
            mMode = M_DONE;
            mCnt  = 0;
          end
        end
      end
      default: begin
        if (tk) begin
          if (!en && key) begin
            mValue = d;
            mMode  = M_ENTRY;
          end else begin
            mCnt = mCnt + 1;
            if (mCnt >= DONE_TICKS) begin
              mMode = M_IDLE;
              mCnt  = 0;
            end
          end
        end
      end
    endcase
  endtask

  function automatic exp_t makeExp();
    exp_t e;
    e.digits   = {4'(mValue / 1000), 4'((mValue / 100) % 10),
                  4'((mValue / 10) % 10), 4'(mValue % 10)};
    e.zero     = (mValue == 0);
    e.counting = (mMode == M_COUNT);
    e.done     = (mMode == M_DONE);
    return e;
  endfunction

  task automatic applyStimulus(input bit c, input bit en, input bit ld, input bit p,
                               input logic [3:0] d, input bit ps);
    @(negedge clk);
    clear   = c;
    enablen = en;
    loadn   = ld;
    pgt_1hz = p;
    D       = d;
    pauseIn = ps;
    modelStep(c, en, ld, p, int'(d), ps);
    expQ.push_back(makeExp());
  endtask

  task automatic checkOutput(input exp_t e);
    logic [15:0] gotDigits;
    logic [2:0]  gotFlags;
    gotDigits = {min_tens, min_ones, sec_tens, sec_ones};
    gotFlags  = {zero, counting, done};
    total++;
    if (gotDigits !== e.digits) begin
      bad++;
      $display("[TB] FAIL digits at %0t: got %h want %h", $time, gotDigits, e.digits);
    end
    total++;
    if (gotFlags !== {e.zero, e.counting, e.done}) begin
      bad++;
      $display("[TB] FAIL flags(zero,counting,done) at %0t: got %b want %b",
               $time, gotFlags, {e.zero, e.counting, e.done});
    end
  endtask

  // Monitor: every settled clock edge, compare the DUT against the oldest expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) checkOutput(expQ.pop_front());
    end
  end

  task automatic doClear();
    applyStimulus(1, 0, 1, 0, 4'd0, 0);
  endtask

  task automatic key(input logic [3:0] d);
    applyStimulus(0, 0, 0, 1, d, 0);
    applyStimulus(0, 0, 1, 0, d, 0);
  endtask

  task automatic tick(input bit en, input bit ps);
    applyStimulus(0, en, 1, 1, 4'd0, ps);
    applyStimulus(0, en, 1, 0, 4'd0, ps);
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) applyStimulus(0, en, 1, 0, 4'd0, 0);
  endtask

  initial begin
    int guard;
    bit rEn;
    bit rPgt;
    logic [3:0] rD;

    doClear();
    doClear();

    // Entry of 01:30
    key(4'd1); key(4'd3); key(4'd0); idle(2, 0);

    // Borrow from minutes: 01:00 -> 00:59 -> 00:58
    doClear();
    key(4'd1); key(4'd0); key(4'd0);
    idle(1, 1); tick(1, 0); tick(1, 0);

    // Finish and done hold-off
    doClear();
    key(4'd2); idle(1, 1);
    tick(1, 0); tick(1, 0); idle(2, 1);
    tick(1, 0); tick(1, 0); tick(1, 0); idle(2, 1);

    // 10:00 -> 09:59, unnormalised 99 -> 98, invalid digit ignored
    doClear();
    key(4'd1); key(4'd0); key(4'd0); key(4'd0); idle(1, 1); tick(1, 0);
    doClear();
    key(4'd9); key(4'd9); idle(1, 1); tick(1, 0);
    doClear();
    key(4'd3); key(4'hC); idle(1, 0);

    // Enable rising with a tick, then a level held high for 50 cycles
    doClear();
    key(4'd5);
    applyStimulus(0, 1, 1, 1, 4'd0, 0);
    for (int i = 0; i < 50; i++) applyStimulus(0, 1, 1, 1, 4'd0, 0);
    applyStimulus(0, 1, 1, 0, 4'd0, 0);
    for (int i = 0; i < 50; i++) applyStimulus(0, 1, 1, 1, 4'd0, 0);
    applyStimulus(0, 1, 1, 0, 4'd0, 0);

    // Pause-and-edit, then clear coincident with a tick
    applyStimulus(0, 0, 1, 0, 4'd0, 0);
    key(4'd7); idle(1, 1); tick(1, 0);
    applyStimulus(1, 1, 1, 1, 4'd0, 0);
    idle(2, 1);

    // Key press while DONE restarts entry with 000D
    doClear();
    key(4'd1); idle(1, 1); tick(1, 0);
    applyStimulus(0, 0, 0, 1, 4'd7, 0);
    idle(2, 0);

    // Pause (only effective when the feature is built in)
    doClear();
    key(4'd1); key(4'd0); idle(1, 1);
    tick(1, 1); tick(1, 1); tick(1, 1); tick(1, 0);

    // Randomised traffic
    doClear();
    rEn  = 1'b0;
    rPgt = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) rEn = ~rEn;
      if ($urandom_range(0, 2) == 0) rPgt = ~rPgt;
      rD = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      applyStimulus($urandom_range(0, 199) == 0, rEn, 1'($urandom_range(0, 1)), rPgt, rD,
                    $urandom_range(0, 3) == 0);
    end

    guard = 0;
    while (expQ.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    if (expQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/timer_countdown.md
Name: timer_countdown

Overview:
Consumer end of the keypad/timer-control interface. It takes the BCD digit bus D, the active-low loadn strobe and the pgt_1hz pulse from the timer-control encoder. In entry mode it shifts keyed digits into a 4-digit MM:SS BCD register. In count mode it decrements that register once per 1 Hz tick to 00:00, then raises done for the magnetron/beeper control.

Parameters:
SEC_WRAP_TENS, 5, seconds-tens value loaded on a minute borrow (seconds wrap to SEC_WRAP_TENS:9 = 59)
DONE_TICKS, 3, number of pgt_1hz ticks done stays high before returning to IDLE (1..15)

Ports:
clk  input  1  system clock; all logic on rising edge
clear  input  1  synchronous, active-high reset
D  input  4  BCD key digit from the encoder (valid 0..9)
loadn  input  1  low = key currently pressed (digit on D valid)
pgt_1hz  input  1  debounced key strobe (enablen=0) or 1 Hz tick (enablen=1); level signal in clk domain
enablen  input  1  0 = entry mode, 1 = count mode (same signal that drives the encoder)
min_tens  output  4  BCD minutes tens
min_ones  output  4  BCD minutes ones
sec_tens  output  4  BCD seconds tens
sec_ones  output  4  BCD seconds ones
zero  output  1  all four digits equal 0 (combinational from registers)
counting  output  1  state == COUNT
done  output  1  countdown finished; held DONE_TICKS ticks

Behaviour:
- Reset: clear=1 at clk edge -> all digits 0, state IDLE, done=0, counting=0, zero=1, edge register pgt_q=0. clear dominates every other event in the same cycle.
- Tick detection: pgt_q <= pgt_1hz; tick = pgt_1hz & ~pgt_q (one-cycle pulse). A level held high produces exactly one tick.
- States: IDLE, ENTRY, COUNT, DONE. Next-state logic is registered; outputs update one cycle after the triggering edge.
- IDLE/ENTRY, enablen=0: on tick with loadn=0 and D<=9, shift left: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D. State becomes ENTRY.
  - D>9 or loadn=1 at tick: no shift.
  - A fifth digit shifts the oldest digit out (discarded).
- IDLE/ENTRY, enablen=1: if zero=0, go to COUNT; otherwise stay in IDLE. The enablen transition has priority over a tick in the same cycle; that tick is not consumed, and the first decrement happens on the next tick.
- COUNT: each tick decrements MM:SS by one second.
  - sec_ones 0 -> 9 with borrow into sec_tens.
  - Seconds 00 -> SEC_WRAP_TENS:9 with borrow into min_ones.
  - min_ones 0 -> 9 with borrow into min_tens.
  - Entered seconds tens above 5 (e.g. 99) count down without normalisation.
  - When the decrement result is 00:00, state becomes DONE in the same update: done=1 and counting=0 on the following cycle.
- COUNT, enablen falls to 0: go to ENTRY with digits retained (pause and edit); no decrement in that cycle.
- DONE: done=1; an internal tick counter counts ticks and returns to IDLE after DONE_TICKS ticks (done=0).
  - A tick with enablen=0 and loadn=0 in DONE goes directly to ENTRY, with digits 000D and done=0.
  - enablen=1 in DONE does not restart counting (zero=1).
- Underflow is impossible: no decrement is ever applied at 00:00.

Optional Feature:
TIMER_PAUSE_EN
- Defined: adds input port pause (1 bit, active-high). In COUNT with pause=1, ticks are ignored: digits hold, state stays COUNT, counting=1. It has no effect in other states.
- Undefined: the port is absent and COUNT decrements on every tick.

Decomposition:
- Package timer_pkg: state enum (IDLE, ENTRY, COUNT, DONE), BCD_MAX=4'd9, BCD_ZERO=4'd0, 4-bit BCD digit typedef.
- One natural sub-module, bcd_down_digit:
  - inputs: digit, borrow_in, wrap value.
  - outputs: next digit, borrow_out.
  - instantiated four times in a ripple chain; the seconds-tens instance uses wrap SEC_WRAP_TENS, all others use 9.

Test Plan:
- Entry: clear, enablen=0, strobe keys 1,3,0 (loadn=0 at each pgt_1hz edge) -> digits 01:30, state ENTRY, zero=0.
- Countdown borrow: load 01:00, enablen=1, 2 ticks -> 00:59 then 00:58; counting=1.
- Finish: load 00:02, enablen=1, 2 ticks -> 00:00, done=1 next cycle; after 3 more ticks -> done=0, IDLE.
- Boundary: load 10:00, 1 tick -> 09:59. Load 99, 1 tick -> 00:98. D=4'hC strobe -> no shift.
- Precedence: tick coincident with enablen rising -> no decrement that cycle. Tick coincident with clear -> all 0, IDLE. Held pgt_1hz high for 50 cycles -> exactly one decrement.
- Pause (TIMER_PAUSE_EN): in COUNT at 00:10, pause=1 for 3 ticks -> stays 00:10; pause=0 plus 1 tick -> 00:09.
